// File: rtl/power_seq_controller.sv
// power_seq_controller: sequences init / issue / wait / load for a runtime exponent, with abort, multiply timeout and range-error reporting.
module power_seq_controller #(
  parameter int MAX_N = 15,
  parameter int TIMEOUT = 64,
  localparam int CNT_W = $clog2(MAX_N + 1),
  localparam int WW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] n_in,
  input  logic             abort,
  input  logic             mul_done,
  output logic             init,
  output logic             inc,
  output logic             mul_start,
  output logic             ld_reg,
  output logic             busy,
  output logic             ready,
  output logic             err,
  output logic [CNT_W-1:0] iter
);
  typedef enum logic [2:0] {IDLE, INIT, ISSUE, WAIT, LOAD, DONE} state_e;
  state_e state_q, state_d;
  logic [CNT_W-1:0] n_q, n_d, iter_q, iter_d;
  logic [WW-1:0] wait_q, wait_d;
  logic err_q, err_d;
  logic timed_out;
  assign timed_out = TIMEOUT != 0 && int'(wait_q) == TIMEOUT - 1;
  always_comb begin
    state_d = state_q;
    n_d = n_q;
    iter_d = iter_q;
    wait_d = wait_q;
    err_d = 1'b0;
    if (abort && state_q != IDLE) state_d = IDLE;
    else case (state_q)
      IDLE: if (start) begin
        if (int'(n_in) > MAX_N) err_d = 1'b1;
        else begin
          n_d = n_in;
          state_d = INIT;
        end
      end
      INIT: begin
        iter_d = '0;
        state_d = n_q == '0 ? DONE : ISSUE;
      end
      ISSUE: begin
        iter_d = iter_q + CNT_W'(1);
        wait_d = '0;
        state_d = WAIT;
      end
      // a late product wins over a timeout expiring in the same cycle
      WAIT: if (mul_done) state_d = LOAD;
      else if (timed_out) begin
        state_d = IDLE;
        err_d = 1'b1;
      end else wait_d = wait_q + WW'(1);
      LOAD: state_d = iter_q == n_q ? DONE : ISSUE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      n_q <= '0;
      iter_q <= '0;
      wait_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q <= n_d;
      iter_q <= iter_d;
      wait_q <= wait_d;
      err_q <= err_d;
    end
  end
  assign init = state_q == INIT;
  assign inc = state_q == ISSUE;
  assign mul_start = state_q == ISSUE;
  assign ld_reg = state_q == LOAD;
  assign busy = state_q != IDLE;
  assign ready = state_q == DONE;
  assign err = err_q;
  assign iter = iter_q;
endmodule

// File: tb/tb_power_seq_controller.sv
// tb_power_seq_controller: directed and randomized operations checked against a cycle-timeline model of the sequencer.
module tb_power_seq_controller;
  localparam int TO = 8;
  logic clk = 1'b0, rst = 1'b1;
  logic start = 1'b0, abort = 1'b0, mul_done = 1'b0;
  logic [3:0] n_in = '0, iter;
  logic init, inc, mul_start, ld_reg, busy, ready, err;
  logic start1 = 1'b0, abort1 = 1'b0, mdone1 = 1'b0;
  logic [3:0] n1 = '0, iter1;
  logic init1, inc1, ms1, ld1, busy1, ready1, err1;
  int errors = 0, checks = 0, op_id = 0;
  int dly[16];
  int last_rdy, last_err, last_iter;
  always #5 clk = ~clk;
  power_seq_controller #(.MAX_N(15), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .start(start), .n_in(n_in), .abort(abort), .mul_done(mul_done),
    .init(init), .inc(inc), .mul_start(mul_start), .ld_reg(ld_reg), .busy(busy),
    .ready(ready), .err(err), .iter(iter));
  power_seq_controller #(.MAX_N(10), .TIMEOUT(0)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .n_in(n1), .abort(abort1), .mul_done(mdone1),
    .init(init1), .inc(inc1), .mul_start(ms1), .ld_reg(ld1), .busy(busy1),
    .ready(ready1), .err(err1), .iter(iter1));
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask
  // a_req: -1 no abort, -2 random abort, otherwise abort high during that cycle
  task automatic run_op(input int n, input bit tie, input bit hold, input int a_req, input bit abort_idle);
    int iss_c[$], ld_c[$];
    int rdy_c = -1, err_c = -1, end_c, t, a, lim;
    int e_iss = 0, e_ld = 0, e_iter = 0, e_rdy, e_err, e_end;
    int c_init = 0, c_inc = 0, c_ms = 0, c_ld = 0, c_rdy = 0, c_err = 0;
    int o_rdy = -1, o_err = -1, cyc = 0, k = 0, done_at = -1;
    bit over = 0;
    string p;
    op_id++;
    p = $sformatf("op%0d n=%0d", op_id, n);
    if (tie) for (int i = 0; i < 16; i++) dly[i] = 0;
    if (n == 0) begin
      rdy_c = 2;
      end_c = 3;
    end else begin
      t = 2;
      for (int j = 0; j < n; j++) begin
        iss_c.push_back(t);
        if (dly[j] >= TO) begin
          err_c = t + 1 + TO;
          end_c = err_c;
          break;
        end
        ld_c.push_back(t + 2 + dly[j]);
        t += 3 + dly[j];
      end
      if (err_c < 0) begin
        rdy_c = t;
        end_c = t + 1;
      end
    end
    a = a_req == -2 ? (($urandom % 4 == 0) ? int'($urandom_range(2, end_c - 1)) : -1) : a_req;
    lim = a >= 0 ? a : 1 << 30;
    e_end = a >= 0 ? a + 1 : end_c;
    foreach (iss_c[i]) begin
      if (iss_c[i] <= lim) e_iss++;
      if (iss_c[i] < lim) e_iter++;
    end
    foreach (ld_c[i]) if (ld_c[i] <= lim) e_ld++;
    e_rdy = (rdy_c >= 0 && rdy_c <= lim) ? rdy_c : -1;
    e_err = (err_c >= 0 && err_c <= lim) ? err_c : -1;
    n_in = 4'(n);
    start = 1'b1;
    abort = abort_idle;
    mul_done = tie;
    do begin
      tick();
      cyc++;
      if (!hold) start = 1'b0;
      if (init) c_init++;
      if (inc) c_inc++;
      if (ld_reg) c_ld++;
      if (mul_start) begin
        c_ms++;
        done_at = cyc + 1 + dly[k];
        k++;
      end
      if (ready) begin
        c_rdy++;
        if (o_rdy < 0) o_rdy = cyc;
      end
      if (err) begin
        c_err++;
        if (o_err < 0) o_err = cyc;
      end
      if (cyc >= 2 && int'(iter) > n) over = 1;
      abort = cyc == a;
      mul_done = tie || cyc == done_at;
    end while (busy && cyc < 1000);
    start = 1'b0;
    abort = 1'b0;
    mul_done = 1'b0;
    chk({p, " end"}, cyc, e_end);
    chk({p, " init"}, c_init, 1);
    chk({p, " inc"}, c_inc, e_iss);
    chk({p, " mul_start"}, c_ms, e_iss);
    chk({p, " ld_reg"}, c_ld, e_ld);
    chk({p, " ready_cyc"}, o_rdy, e_rdy);
    chk({p, " ready_cnt"}, c_rdy, e_rdy >= 0 ? 1 : 0);
    chk({p, " err_cyc"}, o_err, e_err);
    chk({p, " err_cnt"}, c_err, e_err >= 0 ? 1 : 0);
    chk({p, " iter"}, int'(iter), e_iter);
    chk({p, " iter_bound"}, int'(over), 0);
    last_rdy = o_rdy;
    last_err = o_err;
    last_iter = int'(iter);
  endtask
  initial begin
    repeat (2) tick();
    chk("reset strobes", int'({init, inc, mul_start, ld_reg, busy, ready, err}), 0);
    chk("reset iter", int'(iter), 0);
    rst = 1'b0;
    tick();
    run_op(3, 1, 0, -1, 0);
    chk("n3 ready cycle", last_rdy, 11);
    chk("n3 iter", last_iter, 3);
    run_op(0, 1, 0, -1, 0);
    chk("n0 ready cycle", last_rdy, 2);
    for (int i = 0; i < 16; i++) dly[i] = 3;
    run_op(2, 0, 1, -1, 0);
    chk("n2 delayed ready", last_rdy, 14);
    dly[0] = 1000;
    run_op(1, 0, 0, -1, 0);
    chk("timeout err cycle", last_err, 11);
    chk("timeout no ready", last_rdy, -1);
    run_op(15, 1, 0, -1, 1);
    chk("n15 iter", last_iter, 15);
    run_op(4, 1, 0, 7, 0);
    chk("abort in load no ready", last_rdy, -1);
    chk("abort in load iter", last_iter, 2);
    for (int r = 0; r < 25; r++) begin
      for (int i = 0; i < 16; i++) dly[i] = ($urandom % 8 == 0) ? int'($urandom_range(8, 12)) : int'($urandom_range(0, 5));
      run_op(int'($urandom_range(0, 15)), 1'($urandom % 4 == 0), 1'($urandom % 2), -2, 1'($urandom % 2));
    end
    n_in = 4'd5;
    start = 1'b1;
    mul_done = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    mul_done = 1'b0;
    repeat (2) tick();
    chk("midwait busy", int'(busy), 1);
    chk("midwait iter", int'(iter), 2);
    rst = 1'b1;
    tick();
    chk("midwait reset strobes", int'({init, inc, mul_start, ld_reg, busy, ready, err}), 0);
    chk("midwait reset iter", int'(iter), 0);
    rst = 1'b0;
    tick();
    start1 = 1'b1;
    n1 = 4'($urandom_range(11, 15));
    tick();
    chk("range err pulse", int'(err1), 1);
    chk("range err idle", int'(busy1), 0);
    start1 = 1'b0;
    tick();
    chk("range err one cycle", int'(err1), 0);
    start1 = 1'b1;
    n1 = 4'd10;
    tick();
    start1 = 1'b0;
    chk("max legal accepted", int'({busy1, err1}), 2);
    repeat (40) tick();
    chk("no timeout when disabled", int'({busy1, err1, ready1}), 4);
    abort1 = 1'b1;
    tick();
    abort1 = 1'b0;
    chk("abort no err/ready", int'({busy1, err1, ready1}), 0);
    chk("abort keeps iter", int'(iter1), 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
